panda_soft_bits_n: RTL
======================

// Module: panda_soft_bits_n
// PURPOSE
//  N-channel software-driven bit source: the parametrised successor of the fixed four-bit soft-bits block.
//  Each channel is written over the register interface (value + write strobe) and drives one bit onto the system bus.
//  Per-channel mode: LEVEL (hold the written value), PULSE (timed one-shot) or TOGGLE (invert on write).
//  Sits between the register decoder and the bit bus, alongside the other bus-source blocks.
// PARAMETERS
//  N_CH     8   number of soft-bit channels (1..32)
//  PULSE_W  16  width of the shared pulse-length register and of each channel counter
// PORTS
//  clk_i        in   1          system clock; all logic is on its rising edge
//  reset_n_i    in   1          asynchronous active-low reset
//  set_i        in   N_CH       per-channel register value bit
//  set_wstb_i   in   N_CH       per-channel write strobe, 1 cycle
//  mode_i       in   2*N_CH     per-channel mode [2c+1:2c]: 0=LEVEL 1=PULSE 2=TOGGLE 3=reserved(LEVEL)
//  pulse_len_i  in   PULSE_W    PULSE length in clk cycles, shared by all channels
//  commit_i     in   1          apply staged writes (present only with SOFT_BITS_COMMIT_EN)
//  soft_o       out  N_CH       bit-bus outputs
//  busy_o       out  N_CH       1 while a PULSE channel is timing out
// BEHAVIOUR
//  - Reset (async assert, sync release): soft_o=0, busy_o=0, counters=0, staged pending flags=0.
//  - Latency: a strobe at cycle t updates soft_o at t+1. Outputs are registered. Channels are fully independent.
//  - LEVEL: on a strobe, soft <= set.
//  - TOGGLE: on a strobe with set=1, soft <= ~soft. A strobe with set=0 is a no-op.
//  - PULSE, L = max(pulse_len_i,1) sampled on the strobe cycle. A strobe with set=1 at t drives soft=1 and busy=1
//    for cycles t+1..t+L, then soft=0 and busy=0 at t+L+1.
//    - Retrigger (strobe set=1 while busy, including the expiry cycle) reloads the counter. Output stays high with no glitch.
//    - A strobe with set=0 while busy aborts the pulse: soft=0 and busy=0 at t+1.
//    - A change of pulse_len_i mid-pulse does not affect the running pulse.
//  - Mode change: any cycle where a channel's mode_i differs from its previous value clears that channel
//    (soft=0, busy=0, counter=0) at the next cycle.
//    - A strobe in the same cycle is ignored. Firmware writes the mode before the value.
//  - Counter: down-counter, PULSE_W bits, no wrap. Max pulse is 2^PULSE_W-1 cycles. busy_o = (counter != 0).
//  - Reset mid-pulse clears immediately, asynchronously.
// CONFIGURATION
//  SOFT_BITS_COMMIT_EN defined:
//   - Each strobe latches set into a per-channel shadow register and sets a pending flag. soft_o does not change.
//   - commit_i at t applies every pending channel at t+1, using each channel's mode rules, and clears the flags.
//   - A strobe coinciding with commit_i is included in that commit.
//   - Repeated strobes before a commit: last value wins. A TOGGLE channel toggles once per commit.
//  Not defined: commit_i port, shadow and pending logic are absent. Strobes apply directly as above.
// STRUCTURE
//  - panda_soft_bits_pkg: mode localparams (MODE_LEVEL=2'd0, MODE_PULSE=2'd1, MODE_TOGGLE=2'd2) and a mode-decode function.
//  - Sub-module panda_soft_bit_chan: one channel with mode register, counter, soft/busy flops and optional shadow.
//    The top instantiates N_CH copies in a generate loop and slices mode_i.
// TESTING
//  1 LEVEL, ch0: strobe set=1 at ts 10, set=0 at ts 20 -> soft_o[0]=1 on ts 11..20, 0 from ts 21. Other bits stay 0.
//  2 PULSE, ch3, pulse_len=5: strobe set=1 at ts 10 -> soft_o[3]=busy_o[3]=1 on ts 11..15, 0 at 16.
//    pulse_len=0 gives a 1-cycle pulse.
//  3 PULSE retrigger/abort, len=4:
//    - set=1 at ts 10 and 13 -> high on ts 11..17.
//    - set=1 at ts 30, then set=0 at ts 31 -> high on ts 31 only.
//  4 TOGGLE, ch7: set=1 strobes at ts 10, 12, 14 plus set=0 at ts 13 -> soft_o[7] =1 @11, =0 @13, =1 @15.
//  5 Mode change and reset:
//    - ch1 PULSE len=100 started at ts 10; mode set to LEVEL at ts 20 -> soft_o[1]=0 at ts 21.
//    - reset_n_i low at ts 40 mid-pulse -> all outputs 0 immediately.
//  6 With SOFT_BITS_COMMIT_EN: strobes on ch0 (LEVEL, set=1) and ch2 (PULSE, len=3) at ts 10, commit at ts 15
//    -> both rise together at ts 16, ch2 falls at ts 19. Without commit, no change.
//  Every check runs against the bus-out expected-vector file, compared every clock.

Source files
------------

// File: rtl/panda_soft_bits_pkg.sv
// panda_soft_bits_pkg
//   Shared definitions for the N-channel soft-bit source.
//   - MODE_* : per-channel mode encodings carried on mode_i
//   - decode_mode() : folds the reserved encoding onto LEVEL
package panda_soft_bits_pkg;

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;

  // Encoding 3 is reserved and behaves as LEVEL.
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    if (m == MODE_PULSE || m == MODE_TOGGLE) return m;
    return MODE_LEVEL;
  endfunction

endpackage

// File: rtl/panda_soft_bit_chan.sv
// panda_soft_bit_chan
//   One soft-bit channel: mode register, pulse down-counter, soft/busy flops
//   and (with SOFT_BITS_COMMIT_EN defined) a shadow value + pending flag.
// Ports:
//   clk_i, reset_n_i  clock, async active-low reset
//   set_i, set_wstb_i register value bit and its 1-cycle write strobe
//   mode_i[1:0]       channel mode (LEVEL/PULSE/TOGGLE, 3 = LEVEL)
//   pulse_len_i       shared pulse length, 0 treated as 1
//   commit_i          apply staged write (SOFT_BITS_COMMIT_EN only)
//   soft_o            bit-bus output
//   busy_o            pulse timing in progress (counter != 0)
module panda_soft_bit_chan
  import panda_soft_bits_pkg::*;
#(
  parameter int PULSE_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               set_i,
  input  logic               set_wstb_i,
  input  logic [1:0]         mode_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
`ifdef SOFT_BITS_COMMIT_EN
  input  logic               commit_i,
`endif
  output logic               soft_o,
  output logic               busy_o
);

  localparam logic [PULSE_W-1:0] ONE = PULSE_W'(1);

  logic [1:0]         mode_q;
  logic [PULSE_W-1:0] cnt_q;
  logic               soft_q;
  logic               mode_chg;
  logic               apply;
  logic               val;
  logic [PULSE_W-1:0] len_eff;

  // Raw compare: any change of encoding (including to/from reserved) clears.
  assign mode_chg = (mode_i != mode_q);
  assign len_eff  = (pulse_len_i == '0) ? ONE : pulse_len_i;

`ifdef SOFT_BITS_COMMIT_EN
  logic shadow_q;
  logic pend_q;

  // A strobe in the commit cycle bypasses the shadow so it joins that commit.
  assign apply = commit_i & (pend_q | set_wstb_i);
  assign val   = set_wstb_i ? set_i : shadow_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shadow_q <= 1'b0;
      pend_q   <= 1'b0;
    end else if (mode_chg) begin
      pend_q   <= 1'b0;
    end else if (commit_i) begin
      pend_q   <= 1'b0;
    end else if (set_wstb_i) begin
      shadow_q <= set_i;
      pend_q   <= 1'b1;
    end
  end
`else
  assign apply = set_wstb_i;
  assign val   = set_i;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_q <= MODE_LEVEL;
      cnt_q  <= '0;
      soft_q <= 1'b0;
    end else begin
      mode_q <= mode_i;
      if (mode_chg) begin
        // Write in the same cycle as a mode change is dropped.
        cnt_q  <= '0;
        soft_q <= 1'b0;
      end else begin
        case (decode_mode(mode_i))
          MODE_PULSE: begin
            if (apply) begin
              // Reload on retrigger (even in the expiry cycle) keeps soft high.
              cnt_q  <= val ? len_eff : '0;
              soft_q <= val;
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - ONE;
              if (cnt_q == ONE) soft_q <= 1'b0;
            end
          end
          MODE_TOGGLE: begin
            cnt_q <= '0;
            if (apply && val) soft_q <= ~soft_q;
          end
          default: begin
            cnt_q <= '0;
            if (apply) soft_q <= val;
          end
        endcase
      end
    end
  end

  assign soft_o = soft_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/panda_soft_bits_n.sv
// panda_soft_bits_n
//   N-channel software-driven bit source. Each channel is written through the
//   register interface and drives one bit of the system bus in LEVEL, PULSE or
//   TOGGLE mode. Optional feature macro: SOFT_BITS_COMMIT_EN (staged writes
//   applied together on commit_i).
// Ports:
//   clk_i        system clock (rising edge)
//   reset_n_i    async active-low reset
//   set_i        [N_CH]     per-channel value bit
//   set_wstb_i   [N_CH]     per-channel write strobe
//   mode_i       [2*N_CH]   per-channel mode, channel c at [2c+1:2c]
//   pulse_len_i  [PULSE_W]  shared pulse length in cycles (0 -> 1)
//   commit_i                apply staged writes (SOFT_BITS_COMMIT_EN only)
//   soft_o       [N_CH]     bit-bus outputs
//   busy_o       [N_CH]     PULSE channel timing out
module panda_soft_bits_n
  import panda_soft_bits_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int PULSE_W = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [N_CH-1:0]     set_i,
  input  logic [N_CH-1:0]     set_wstb_i,
  input  logic [2*N_CH-1:0]   mode_i,
  input  logic [PULSE_W-1:0]  pulse_len_i,
`ifdef SOFT_BITS_COMMIT_EN
  input  logic                commit_i,
`endif
  output logic [N_CH-1:0]     soft_o,
  output logic [N_CH-1:0]     busy_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    panda_soft_bit_chan #(
      .PULSE_W (PULSE_W)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .set_i       (set_i[c]),
      .set_wstb_i  (set_wstb_i[c]),
      .mode_i      (mode_i[2*c +: 2]),
      .pulse_len_i (pulse_len_i),
`ifdef SOFT_BITS_COMMIT_EN
      .commit_i    (commit_i),
`endif
      .soft_o      (soft_o[c]),
      .busy_o      (busy_o[c])
    );
  end

endmodule
